// File: rtl/sd_pulse_pacer.sv
// sd_pulse_pacer
//   Source-side event pacer for a pulse synchronizer. Single-cycle event
//   pulses arriving at any rate, including back-to-back, are queued in a
//   saturating pending counter. They are re-emitted as single-cycle pulses
//   whose rising edges are at least min_gap cycles apart.
//
//   Parameters
//     min_gap   : minimum cycles between pulse_out rising edges (2..256)
//     cnt_width : pending counter width; holds up to 2^cnt_width-1 events
//
//   Ports
//     clk       : block clock
//     reset_n   : synchronous active-low reset
//     pulse_in  : event strobe, one event per high cycle
//     flush     : discard all queued events
//     clr_ovf   : clear the sticky overflow flag
//     pulse_out : registered paced event pulse
//     pending   : registered count of queued, not-yet-emitted events
//     busy      : events queued or spacing gap in progress
//     overflow  : sticky, set when an event is dropped at saturation
//
//   state | meaning
//   IDLE  | free to emit; emits when an event is queued or arriving
//   GAP   | enforcing spacing after an emit; lasts min_gap-1 cycles

module sd_pulse_pacer #(
   parameter int min_gap   = 4,
   parameter int cnt_width = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 pulse_in,
   input  logic                 flush,
   input  logic                 clr_ovf,
   output logic                 pulse_out,
   output logic [cnt_width-1:0] pending,
   output logic                 busy,
   output logic                 overflow
);

   localparam int gap_w = (min_gap > 2) ? $clog2(min_gap - 1) : 1;
   localparam logic [gap_w-1:0]     gap_load = gap_w'(min_gap - 2);
   localparam logic [cnt_width-1:0] pend_max = '1;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [gap_w-1:0]     gap_cnt_q, gap_cnt_d;
   logic                 pulse_out_q, pulse_out_d;
   logic [cnt_width-1:0] pending_q, pending_d;
   logic                 overflow_q, overflow_d;
   logic                 emit;
   logic                 drop;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         gap_cnt_q   <= '0;
         pulse_out_q <= 1'b0;
         pending_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         pulse_out_q <= pulse_out_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      pulse_out_d = 1'b0;
      pending_d   = pending_q;
      overflow_d  = overflow_q;

      emit = (state_q == IDLE) && ((pending_q != '0) || pulse_in);
      drop = pulse_in && !emit && (pending_q == pend_max);

      case (state_q)
         IDLE: begin
            if (emit) begin
               state_d     = GAP;
               gap_cnt_d   = gap_load;
               pulse_out_d = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - gap_w'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An emit with nothing queued consumes the arriving pulse directly;
      // an emit with a pulse arriving swaps one queued event for the new one.
      if (flush) begin
         pending_d = '0;
      end else if (emit) begin
         if ((pending_q != '0) && !pulse_in) begin
            pending_d = pending_q - cnt_width'(1);
         end
      end else if (pulse_in && (pending_q != pend_max)) begin
         pending_d = pending_q + cnt_width'(1);
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   assign pulse_out = pulse_out_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;
   assign busy      = (pending_q != '0) || (state_q == GAP);

endmodule

// File: tb/tb_sd_pulse_pacer.sv
module tb_sd_pulse_pacer;

   localparam int MIN_GAP = 4;
   localparam int CNT_W   = 3;
   localparam int MAX_Q   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             pulse_in;
   logic             flush;
   logic             clr_ovf;
   logic             pulse_out;
   logic [CNT_W-1:0] pending;
   logic             busy;
   logic             overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: events are a count, and an emit is allowed whenever an
   // event is available and at least MIN_GAP cycles have passed since the
   // previous emit decision.
   int cyc    = 0;
   int m_pend = 0;
   int m_last = -1000;
   bit m_ovf  = 1'b0;

   sd_pulse_pacer #(
      .min_gap   (MIN_GAP),
      .cnt_width (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pulse_in  (pulse_in),
      .flush     (flush),
      .clr_ovf   (clr_ovf),
      .pulse_out (pulse_out),
      .pending   (pending),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit pi, input bit fl, input bit co, input bit rn);
      bit idle, emit, drop, exp_po, exp_busy;
      pulse_in = pi;
      flush    = fl;
      clr_ovf  = co;
      reset_n  = rn;
      if (!rn) begin
         m_pend = 0;
         m_ovf  = 1'b0;
         m_last = -1000;
         exp_po = 1'b0;
      end else begin
         idle   = (cyc - m_last) >= MIN_GAP;
         emit   = idle && ((m_pend > 0) || pi);
         drop   = pi && !emit && (m_pend == MAX_Q);
         exp_po = emit;
         if (emit) m_last = cyc;
         if (fl) m_pend = 0;
         else if (emit) begin
            if ((m_pend > 0) && !pi) m_pend = m_pend - 1;
         end else if (pi && (m_pend < MAX_Q)) m_pend = m_pend + 1;
         if (drop) m_ovf = 1'b1;
         else if (co) m_ovf = 1'b0;
      end
      cyc++;
      exp_busy = (m_pend != 0) || ((cyc - m_last) < MIN_GAP);
      @(posedge clk);
      #1;
      check("pulse_out", 32'(pulse_out), 32'(exp_po));
      check("pending",   32'(pending),   32'(m_pend));
      check("busy",      32'(busy),      32'(exp_busy));
      check("overflow",  32'(overflow),  32'(m_ovf));
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic burst(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset_n  = 1'b0;
      pulse_in = 1'b0;
      flush    = 1'b0;
      clr_ovf  = 1'b0;

      // reset
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_pulse_out", 32'(pulse_out), 32'd0);
      check("rst_pending",   32'(pending),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);

      // isolated pulse after idle: output one cycle later, nothing queued
      idle_n(9);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("iso_pulse_out", 32'(pulse_out), 32'd1);
      check("iso_pending",   32'(pending),   32'd0);
      check("iso_busy",      32'(busy),      32'd1);
      idle_n(8);

      // back-to-back burst of 5
      burst(5);
      idle_n(22);

      // saturation and overflow
      burst(14);
      check("sat_overflow", 32'(overflow), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("clr_overflow", 32'(overflow), 32'd0);
      // keep feeding while clearing every cycle: drops must win over clear
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      idle_n(40);
      step(1'b0, 1'b0, 1'b1, 1'b1);

      // flush while queued during a gap
      burst(4);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("flush_pending", 32'(pending), 32'd0);
      idle_n(6);

      // reset with events queued mid-gap
      burst(6);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_rst_pulse", 32'(pulse_out), 32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("post_rst_pulse", 32'(pulse_out), 32'd1);
      idle_n(5);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit pi, fl, co, rn;
         int phase;
         phase = (i / 100) % 2;
         pi = ($urandom_range(99) < (phase != 0 ? 85 : 40));
         fl = ($urandom_range(99) < 3);
         co = ($urandom_range(99) < 6);
         rn = ($urandom_range(199) != 0);
         step(pi, fl, co, rn);
      end
      idle_n(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
